// File: rtl/nx_indirect_access_mem_arb.sv
// nx_indirect_access_mem_arb: flop table with hw/sw arbitration, single reads/writes and group compare
module nx_indirect_access_mem_arb #(
  parameter int N_ENTRIES = 32,
  parameter int N_ADDR_BITS = 5,
  parameter int N_DATA_BITS = 64,
  parameter int N_GROUP = 16,
  parameter int STARVE_LIMIT = 7,
  localparam int G_BITS = $clog2(N_GROUP)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   sw_cs,
  input  logic                   sw_ce,
  input  logic                   sw_we,
  input  logic                   sw_reset,
  input  logic [N_ADDR_BITS-1:0] sw_add,
  input  logic [N_DATA_BITS-1:0] sw_wdat,
  output logic [N_DATA_BITS-1:0] sw_rdat,
  output logic                   sw_match,
  output logic [G_BITS-1:0]      sw_aindex,
  output logic                   grant,
  input  logic                   yield,
  input  logic                   hw_rd,
  input  logic                   hw_wr,
  input  logic [N_ADDR_BITS-1:0] hw_add,
  input  logic [N_DATA_BITS-1:0] hw_wdat,
  output logic [N_DATA_BITS-1:0] hw_rdat,
  output logic                   hw_rvld,
  output logic                   hw_stall
);
  logic [N_DATA_BITS-1:0] mem [N_ENTRIES];
  logic [N_ENTRIES-1:0]   valid;
  logic [3:0]             wait_cnt;
  logic                   hw_req, frc, sw_wr, sw_rd, sw_cmp, hw_go;
  logic [N_GROUP-1:0]     hit;
  logic [G_BITS-1:0]      first;
  logic [N_ADDR_BITS-1:0] idx;

  assign hw_req   = hw_rd | hw_wr;
  assign frc      = yield | (wait_cnt == 4'(STARVE_LIMIT));
  assign grant    = sw_cs & (!hw_req | frc);
  assign hw_stall = hw_req & grant;
  assign sw_wr    = grant & sw_we;
  assign sw_rd    = grant & !sw_we & !sw_ce;
  assign sw_cmp   = grant & sw_ce & !sw_we;
  assign hw_go    = hw_req & !grant;

  // lowest matching slot wins, so scan downward and let later hits overwrite
  always_comb begin
    first = '0;
    idx = '0;
    for (int i = 0; i < N_GROUP; i++) begin
      idx = {sw_add[N_ADDR_BITS-1:G_BITS], G_BITS'(i)};
      hit[i] = valid[idx] && (mem[idx] == sw_wdat);
    end
    for (int i = N_GROUP - 1; i >= 0; i--) first = hit[i] ? G_BITS'(i) : first;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_ENTRIES; i++) mem[i] <= '0;
      valid     <= '0;
      wait_cnt  <= '0;
      sw_rdat   <= '0;
      sw_match  <= 1'b0;
      sw_aindex <= '0;
      hw_rdat   <= '0;
      hw_rvld   <= 1'b0;
    end else begin
      if (sw_wr) begin
        mem[sw_add]   <= sw_reset ? '0 : sw_wdat;
        valid[sw_add] <= !sw_reset;
      end else if (hw_go && hw_wr) begin
        mem[hw_add]   <= hw_wdat;
        valid[hw_add] <= 1'b1;
      end
      if (sw_rd) sw_rdat <= mem[sw_add];
      if (sw_cmp) begin
        sw_match  <= |hit;
        sw_aindex <= first;
      end
      if (hw_go && hw_rd) hw_rdat <= mem[hw_add];
      hw_rvld  <= hw_go & hw_rd;
      wait_cnt <= (grant || !sw_cs) ? '0 : (frc ? wait_cnt : wait_cnt + 4'd1);
    end
  end
endmodule

// File: tb/tb_nx_indirect_access_mem_arb.sv
// tb_nx_indirect_access_mem_arb: directed scoreboard bench for the table/arbiter stage
module tb_nx_indirect_access_mem_arb;
  logic        clk = 1'b0, rst_n = 1'b1;
  logic        sw_cs, sw_ce, sw_we, sw_reset, yield, hw_rd, hw_wr;
  logic [4:0]  sw_add, hw_add;
  logic [63:0] sw_wdat, hw_wdat, sw_rdat, hw_rdat;
  logic        sw_match, grant, hw_rvld, hw_stall;
  logic [3:0]  sw_aindex;

  typedef struct {
    string       tag;
    int          kind;
    logic [63:0] val;
  } exp_t;
  exp_t q[$];
  int checks = 0, errors = 0;

  nx_indirect_access_mem_arb dut (
    .clk(clk), .rst_n(rst_n), .sw_cs(sw_cs), .sw_ce(sw_ce), .sw_we(sw_we),
    .sw_reset(sw_reset), .sw_add(sw_add), .sw_wdat(sw_wdat), .sw_rdat(sw_rdat),
    .sw_match(sw_match), .sw_aindex(sw_aindex), .grant(grant), .yield(yield),
    .hw_rd(hw_rd), .hw_wr(hw_wr), .hw_add(hw_add), .hw_wdat(hw_wdat),
    .hw_rdat(hw_rdat), .hw_rvld(hw_rvld), .hw_stall(hw_stall)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] obs_of(input int kind);
    return kind == 0 ? sw_rdat : kind == 1 ? {63'd0, sw_match} : kind == 2 ? {60'd0, sw_aindex} :
           kind == 3 ? hw_rdat : {63'd0, hw_rvld};
  endfunction

  task automatic push(input string tag, input int kind, input logic [63:0] val);
    exp_t e;
    e.tag = tag;
    e.kind = kind;
    e.val = val;
    q.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    while (q.size() > 0) begin
      e = q.pop_front();
      cmp(e.tag, obs_of(e.kind), e.val);
    end
  endtask

  task automatic go_sw(input logic cs, we, ce, rs, input logic [4:0] a, input logic [63:0] d);
    @(negedge clk);
    sw_cs = cs; sw_we = we; sw_ce = ce; sw_reset = rs; sw_add = a; sw_wdat = d;
  endtask

  task automatic hw_set(input logic rd, wr, input logic [4:0] a, input logic [63:0] d);
    hw_rd = rd; hw_wr = wr; hw_add = a; hw_wdat = d;
  endtask

  task automatic comb(input string tag, input logic g, input logic s);
    #1;
    cmp({tag, "_grant"}, {63'd0, grant}, {63'd0, g});
    cmp({tag, "_stall"}, {63'd0, hw_stall}, {63'd0, s});
  endtask

  task automatic reset_checks(input string tag);
    cmp({tag, "_rdat"}, sw_rdat, 0);
    cmp({tag, "_match"}, {63'd0, sw_match}, 0);
    cmp({tag, "_aidx"}, {60'd0, sw_aindex}, 0);
    cmp({tag, "_hwrdat"}, hw_rdat, 0);
    cmp({tag, "_rvld"}, {63'd0, hw_rvld}, 0);
  endtask

  initial begin
    sw_cs = 0; sw_ce = 0; sw_we = 0; sw_reset = 0; yield = 0;
    sw_add = 0; sw_wdat = 0;
    hw_set(0, 0, 0, 0);
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_checks("rst");
    cmp("rst_grant", {63'd0, grant}, 0);
    cmp("rst_stall", {63'd0, hw_stall}, 0);
    @(negedge clk) rst_n = 1'b1;
    go_sw(1, 0, 0, 0, 3, 0); comb("rd3", 1, 0);
    push("rd3_rdat", 0, 0); push("rd3_rvld", 4, 0); tick();
    go_sw(1, 1, 0, 0, 17, 64'hDEAD_BEEF); comb("wr17", 1, 0); tick();
    go_sw(1, 0, 1, 0, 16, 64'hDEAD_BEEF); comb("cmp16", 1, 0);
    push("cmp16_match", 1, 1); push("cmp16_aidx", 2, 1); tick();
    go_sw(1, 0, 0, 0, 17, 0); push("rd17_rdat", 0, 64'hDEAD_BEEF); tick();
    go_sw(1, 0, 1, 0, 0, 64'hDEAD_BEEF);
    push("cmp0_match", 1, 0); push("cmp0_aidx", 2, 0); push("cmp0_rdat", 0, 64'hDEAD_BEEF); tick();
    go_sw(1, 1, 0, 0, 20, 64'h55); tick();
    go_sw(1, 1, 0, 0, 22, 64'h55); tick();
    go_sw(1, 0, 1, 0, 16, 64'h55); push("cmp55_match", 1, 1); push("cmp55_aidx", 2, 4); tick();
    go_sw(1, 1, 0, 1, 20, 64'h55); tick();
    go_sw(1, 0, 1, 0, 31, 64'h55); push("cmpclr_match", 1, 1); push("cmpclr_aidx", 2, 6); tick();
    go_sw(1, 0, 0, 0, 20, 0); push("rd20_rdat", 0, 0); tick();
    // hardware reads hog the table; software must win on the 8th cycle
    go_sw(1, 0, 0, 0, 22, 0); hw_set(1, 0, 17, 0);
    for (int c = 1; c <= 7; c++) begin
      if (c > 1) @(negedge clk);
      comb($sformatf("starve%0d", c), 0, 0);
      push("starve_rvld", 4, 1); push("starve_hwrdat", 3, 64'hDEAD_BEEF); tick();
    end
    @(negedge clk); comb("forced", 1, 1);
    push("forced_rdat", 0, 64'h55); push("forced_rvld", 4, 0); tick();
    go_sw(0, 0, 0, 0, 0, 0); comb("resume", 0, 0); push("resume_rvld", 4, 1); tick();
    go_sw(1, 0, 0, 0, 5, 0); yield = 1; hw_set(0, 1, 5, 64'h1234); comb("yield", 1, 1);
    push("yield_rdat", 0, 0); push("yield_rvld", 4, 0); tick();
    go_sw(0, 0, 0, 0, 0, 0); yield = 0; hw_set(1, 0, 5, 0); comb("hwrd5", 0, 0);
    push("hwrd5_rdat", 3, 0); push("hwrd5_rvld", 4, 1); tick();
    @(negedge clk); hw_set(0, 1, 5, 64'h1234); comb("hwwr5", 0, 0);
    push("hwwr5_rvld", 4, 0); tick();
    go_sw(1, 0, 0, 0, 5, 0); hw_set(0, 0, 0, 0); comb("rd5", 1, 0);
    push("rd5_rdat", 0, 64'h1234); tick();
    // reset lands while a hardware write is pending
    go_sw(0, 0, 0, 0, 0, 0); hw_set(0, 1, 9, 64'hABCD);
    #2 rst_n = 1'b0;
    @(posedge clk); #1;
    reset_checks("midrst");
    @(negedge clk); rst_n = 1'b1; hw_set(0, 0, 0, 0);
    go_sw(1, 0, 1, 0, 0, 64'hABCD); push("post9_match", 1, 0); push("post9_aidx", 2, 0); tick();
    go_sw(1, 0, 1, 0, 0, 0); push("postinv_match", 1, 0); tick();
    go_sw(1, 1, 0, 0, 2, 64'h77); tick();
    go_sw(1, 0, 0, 0, 2, 0); push("rd2_rdat", 0, 64'h77); tick();
    go_sw(1, 0, 0, 0, 5, 0); push("post5_rdat", 0, 0); tick();
    go_sw(0, 0, 0, 0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
